// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle 16-bit-instruction MIPS-style core:
// opcodes, instruction field positions, FSM states and ALU control codes.
package mips_mc_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_BEQ  = 4'b0101;
  localparam logic [3:0] OP_BNE  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RS_MSB  = 11;
  localparam int unsigned RS_LSB  = 10;
  localparam int unsigned RT_MSB  = 9;
  localparam int unsigned RT_LSB  = 8;
  localparam int unsigned RD_MSB  = 7;
  localparam int unsigned RD_LSB  = 6;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctl_t;

  function automatic alu_ctl_t alu_ctl(input logic [3:0] op);
    case (op)
      OP_SUB, OP_BEQ, OP_BNE: alu_ctl = ALU_SUB;
      OP_AND:                 alu_ctl = ALU_AND;
      OP_OR:                  alu_ctl = ALU_OR;
      OP_SLT:                 alu_ctl = ALU_SLT;
      default:                alu_ctl = ALU_ADD;
    endcase
  endfunction

  function automatic logic op_writes(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_SLT: op_writes = 1'b1;
      default:                                        op_writes = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// Four-entry register file: two combinational read ports, one write port,
// register $0 hard-wired to zero.
module mc_regfile
  import mips_mc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        ra1,
  input  logic [1:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [1:0]        wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs [1:3];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regs[1] <= '0;
      regs[2] <= '0;
      regs[3] <= '0;
    end else if (we && wa != 2'd0) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != 2'd0) rd1 = regs[ra1];
    if (ra2 != 2'd0) rd2 = regs[ra2];
  end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle core: FETCH (handshaked) -> DECODE -> EXEC -> WB, with a
// terminal HALT state left only through reset.
module mips_multicycle_core
  import mips_mc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [15:0]       ir,
  output logic              wb_en,
  output logic [1:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              retire,
  output logic              halted
);

  state_t            state, state_nx;
  logic              started;
  logic [PC_W-1:0]   pc, pc_branch, imm_pc;
  logic [DATA_W-1:0] a, b, alu_out, alu_y, opnd_b, diff, imm_d, rd1, rd2;
  logic              take, cond, ovf, lt;
  logic [3:0]        op;
  logic [1:0]        rs, rt, rd;
  logic [7:0]        imm;

  assign op  = ir[OP_MSB:OP_LSB];
  assign rs  = ir[RS_MSB:RS_LSB];
  assign rt  = ir[RT_MSB:RT_LSB];
  assign rd  = ir[RD_MSB:RD_LSB];
  assign imm = ir[IMM_MSB:IMM_LSB];

  assign imm_d     = DATA_W'($signed(imm));
  assign imm_pc    = PC_W'($signed(imm));
  assign pc_branch = pc + PC_W'(2) + (imm_pc << 1);
  assign imem_addr = pc;
  assign wb_data   = alu_out;

  mc_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .ra1     (rs),
    .ra2     (rt),
    .rd1     (rd1),
    .rd2     (rd2),
    .we      (wb_en),
    .wa      (wb_addr),
    .wd      (alu_out)
  );

  // Signed less-than from the subtraction: sign of the difference corrected
  // by overflow, so extreme operands compare correctly.
  always_comb begin
    opnd_b = (op == OP_ADDI) ? imm_d : b;
    diff   = a - b;
    ovf    = (a[DATA_W-1] ^ b[DATA_W-1]) & (diff[DATA_W-1] ^ a[DATA_W-1]);
    lt     = diff[DATA_W-1] ^ ovf;
    case (alu_ctl(op))
      ALU_SUB: alu_y = diff;
      ALU_AND: alu_y = a & b;
      ALU_OR:  alu_y = a | b;
      ALU_SLT: alu_y = DATA_W'(lt);
      default: alu_y = a + opnd_b;
    endcase
    cond = 1'b0;
    if (op == OP_BEQ) cond = (a == b);
    if (op == OP_BNE) cond = (a != b);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= FETCH;
      started <= 1'b0;
    end else begin
      state   <= state_nx;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    imem_req = 1'b0;
    wb_en    = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;
    case (state)
      FETCH: begin
        imem_req = started;
        if (started && imem_valid) state_nx = DECODE;
      end
      DECODE: state_nx = EXEC;
      EXEC:   state_nx = WB;
      WB: begin
        wb_en    = op_writes(op);
        retire   = 1'b1;
        state_nx = (op == OP_HALT) ? HALT : FETCH;
      end
      HALT:    halted = 1'b1;
      default: state_nx = FETCH;
    endcase
  end

  // alu_out/wb_addr load only for writing opcodes so wb_addr/wb_data keep
  // the last written value between writes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc      <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      wb_addr <= '0;
      take    <= 1'b0;
    end else begin
      case (state)
        FETCH: if (imem_req && imem_valid) ir <= imem_rdata;
        DECODE: begin
          a <= rd1;
          b <= rd2;
        end
        EXEC: begin
          take <= cond;
          if (op_writes(op)) begin
            alu_out <= alu_y;
            wb_addr <= (op == OP_ADDI) ? rt : rd;
          end
        end
        WB: pc <= take ? pc_branch : pc + PC_W'(2);
        default: ;
      endcase
    end
  end

endmodule
